// File: rtl/voter_switch_pkg.sv
// -----------------------------------------------------------------------------
// voter_switch_pkg
//   Shared definitions for the voter_switch block: the one-hot verdict
//   encodings driven onto O and the helper that sizes the yes-vote counter.
// -----------------------------------------------------------------------------
package voter_switch_pkg;

   localparam logic [2:0] VERDICT_NONE = 3'b000;
   localparam logic [2:0] VERDICT_PASS = 3'b001;
   localparam logic [2:0] VERDICT_TIE  = 3'b010;
   localparam logic [2:0] VERDICT_FAIL = 3'b100;

   // Bits needed to hold a count of 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage : voter_switch_pkg

// File: rtl/voter_popcount.sv
// -----------------------------------------------------------------------------
// voter_popcount
//   Purely combinational population count of the vote vector.
// Ports
//   v      in   [N-1:0]             vote bits, 1 = yes
//   count  out  [cnt_width(N)-1:0]  number of bits set in v
// -----------------------------------------------------------------------------
module voter_popcount
   import voter_switch_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]              v,
   output logic [cnt_width(N)-1:0]   count
);

   localparam int CW = cnt_width(N);

   logic [CW-1:0] sum_s;

   // Ripple adder chain: accumulate one vote bit per iteration.
   always_comb begin
      sum_s = {CW{1'b0}};
      for (int i = 0; i < N; i++) begin
         sum_s = sum_s + {{(CW-1){1'b0}}, v[i]};
      end
   end

   assign count = sum_s;

endmodule : voter_popcount

// File: rtl/voter_switch.sv
// -----------------------------------------------------------------------------
// voter_switch
//   Registered vote tallier. Counts the yes votes on I and reports a one-hot
//   verdict on O one clock later. O = 000 means "no verdict" (in reset).
// Ports
//   clk    in   1                          system clock, rising edge
//   rst    in   1                          synchronous, active-high reset
//   I      in   [N_VOTERS-1:0]             votes, 1 = yes; MSB is the chair
//   O      out  [3:1]                      O[1] pass, O[2] tie, O[3] fail
//   count  out  [cnt_width(N_VOTERS)-1:0]  registered yes-vote count
// Configuration
//   CHAIR_TIEBREAK_EN  when defined, a tie is resolved by the chair vote
//                      (chair yes -> pass, chair no -> fail); no tie verdict.
// -----------------------------------------------------------------------------
module voter_switch
   import voter_switch_pkg::*;
#(
   parameter int N_VOTERS = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_VOTERS-1:0]               I,
   output logic [3:1]                        O,
   output logic [cnt_width(N_VOTERS)-1:0]    count
);

   localparam int CW = cnt_width(N_VOTERS);
   // N_VOTERS always fits in CW bits, so this compare operand is exact.
   localparam logic [CW:0] N_CMP = (CW+1)'(N_VOTERS);

   logic [CW-1:0] count_s;
   logic [CW:0]   twice_s;
   logic [2:0]    verdict_s;
   logic [2:0]    verdict_r;
   logic [CW-1:0] count_r;

   voter_popcount #(
      .N     (N_VOTERS)
   ) u_popcount (
      .v     (I),
      .count (count_s)
   );

   // Doubling the count avoids a fractional majority threshold.
   assign twice_s = {count_s, 1'b0};

   // Verdict decode from the doubled count versus the voter total.
   always_comb begin
      verdict_s = VERDICT_NONE;
      if (twice_s > N_CMP) begin
         verdict_s = VERDICT_PASS;
      end else if (twice_s < N_CMP) begin
         verdict_s = VERDICT_FAIL;
      end else begin
`ifdef CHAIR_TIEBREAK_EN
         if (I[N_VOTERS-1]) begin
            verdict_s = VERDICT_PASS;
         end else begin
            verdict_s = VERDICT_FAIL;
         end
`else
         verdict_s = VERDICT_TIE;
`endif
      end
   end

   // Output register stage; reset wins over the sample on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         verdict_r <= VERDICT_NONE;
         count_r   <= {CW{1'b0}};
      end else begin
         verdict_r <= verdict_s;
         count_r   <= count_s;
      end
   end

   assign O     = verdict_r;
   assign count = count_r;

endmodule : voter_switch

// File: tb/tb_voter_switch.sv
module tb_voter_switch;

   logic       clk;
   logic       rst;
   logic [3:0] I;
   logic [3:1] O;
   logic [2:0] count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic       rst;
      logic [3:0] i;
      logic [2:0] o;
      logic [2:0] cnt;
   } vec_t;

   vec_t vecs [9];

   voter_switch #(.N_VOTERS(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .I     (I),
      .O     (O),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply(input logic r, input logic [3:0] v);
      @(negedge clk);
      rst = r;
      I   = v;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int idx,
                        input logic [2:0] exp_o, input logic [2:0] exp_c);
      total_cnt++;
      if (O === exp_o && count === exp_c) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s[%0d] I=%b rst=%b: O=%b count=%0d, expected O=%b count=%0d",
                  tag, idx, I, rst, O, count, exp_o, exp_c);
      end
   endtask

   // Reference model: thresholds of the N=4 truth table.
   function automatic logic [2:0] model_o(input logic [3:0] v);
      int c;
      c = $countones(v);
      if (c >= 3) return 3'b001;
      if (c <= 1) return 3'b100;
`ifdef CHAIR_TIEBREAK_EN
      return v[3] ? 3'b001 : 3'b100;
`else
      return 3'b010;
`endif
   endfunction

   initial begin
      rst = 1'b1;
      I   = 4'b1111;

      vecs[0] = '{1'b1, 4'b1111, 3'b000, 3'd0};
      vecs[1] = '{1'b1, 4'b1111, 3'b000, 3'd0};
      vecs[2] = '{1'b0, 4'b1111, 3'b001, 3'd4};
      vecs[3] = '{1'b0, 4'b0000, 3'b100, 3'd0};
      vecs[4] = '{1'b0, 4'b0001, 3'b100, 3'd1};
`ifdef CHAIR_TIEBREAK_EN
      vecs[5] = '{1'b0, 4'b0011, 3'b100, 3'd2};
      vecs[6] = '{1'b0, 4'b1100, 3'b001, 3'd2};
`else
      vecs[5] = '{1'b0, 4'b0011, 3'b010, 3'd2};
      vecs[6] = '{1'b0, 4'b1100, 3'b010, 3'd2};
`endif
      vecs[7] = '{1'b0, 4'b0111, 3'b001, 3'd3};
      vecs[8] = '{1'b0, 4'b1011, 3'b001, 3'd3};

      for (int k = 0; k < 9; k++) begin
         apply(vecs[k].rst, vecs[k].i);
         check("vec", k, vecs[k].o, vecs[k].cnt);
      end

      // Sweep every input value, holding each for 5 cycles; a one-cycle
      // reset pulse lands on the first cycle of I=1110.
      for (int v = 0; v < 16; v++) begin
         for (int c = 0; c < 5; c++) begin
            if (v == 14 && c == 0) begin
               apply(1'b1, 4'(v));
               check("sweep_rst", v, 3'b000, 3'd0);
            end else begin
               apply(1'b0, 4'(v));
               check("sweep", v, model_o(4'(v)), 3'($countones(4'(v))));
               total_cnt++;
               if ($onehot(O)) begin
                  pass_cnt++;
               end else begin
                  $display("FAIL onehot[%0d] O=%b, expected exactly one bit set", v, O);
               end
            end
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_voter_switch
